// File: rtl/rr_trace_buf_ctrl.sv
// rr_trace_buf_ctrl: hands host-supplied trace buffers to a trace writer, one at a time,
// and reports each completed buffer back to the host.
//
// The host queues buffer descriptors (64-byte aligned base address and non-zero size that is
// a multiple of 64) in a small FIFO. Malformed descriptors still complete their handshake,
// but they are dropped and flagged. The FSM programs one buffer into the writer and waits
// for the writer's interrupt (buffer full or closed). When the interrupt arrives, it pushes
// a completion {seq, last} into a second FIFO. A record_finish request ends the trace. The
// final completion carries last = 1, and the block then stays in DONE until reset.
//
// Ports
//   clk, sync_rst_n                 clock; asynchronous active-low reset
//   desc_valid/desc_ready           descriptor handshake (desc_addr, desc_size)
//   write_buf_addr/size/update      registered descriptor plus a one-cycle latch pulse to the writer
//   write_interrupt, record_finish  one-cycle event pulses from the writer and the recorder
//   done_valid/done_ready           completion handshake (done_seq, done_last)
//   starved                         recording active but no buffer programmed
//   err_bad_desc, err_done_ovf      sticky error flags
//   buf_cnt                         buffers programmed since reset (wraps)
module rr_trace_buf_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned DESC_DEPTH     = 4,
    parameter int unsigned DONE_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      sync_rst_n,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] desc_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] desc_size,
    output logic [AXI_ADDR_WIDTH-1:0] write_buf_addr,
    output logic [AXI_ADDR_WIDTH-1:0] write_buf_size,
    output logic                      write_buf_update,
    input  logic                      write_interrupt,
    input  logic                      record_finish,
    output logic                      done_valid,
    input  logic                      done_ready,
    output logic [15:0]               done_seq,
    output logic                      done_last,
    output logic                      starved,
    output logic                      err_bad_desc,
    output logic                      err_done_ovf,
    output logic [15:0]               buf_cnt
);

    localparam int unsigned DescAw = $clog2(DESC_DEPTH);
    localparam int unsigned DoneAw = $clog2(DONE_DEPTH);
    localparam logic [DescAw:0] DescPtrOne = {{DescAw{1'b0}}, 1'b1};
    localparam logic [DoneAw:0] DonePtrOne = {{DoneAw{1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StProgram, StActive, StDrain, StDone} state_e;

    state_e state_q, state_d;

    // ---------------------------------------------------------------- descriptor FIFO
    logic [AXI_ADDR_WIDTH-1:0] desc_addr_mem [DESC_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] desc_size_mem [DESC_DEPTH];
    logic [DescAw:0]           desc_wptr_q, desc_rptr_q;
    logic                      desc_empty, desc_full;
    logic                      desc_fire, desc_bad, desc_push, desc_pop;
    logic                      ready_en_q;

    assign desc_empty = (desc_wptr_q == desc_rptr_q);
    assign desc_full  = (desc_wptr_q[DescAw] != desc_rptr_q[DescAw]) &&
                        (desc_wptr_q[DescAw-1:0] == desc_rptr_q[DescAw-1:0]);

    // Keeps desc_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    assign desc_ready = ready_en_q && !desc_full && (state_q != StDone);
    assign desc_fire  = desc_valid && desc_ready;
    assign desc_bad   = (desc_size == '0) || (desc_size[5:0] != 6'd0) ||
                        (desc_addr[5:0] != 6'd0);
    assign desc_push  = desc_fire && !desc_bad;

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            desc_wptr_q <= '0;
            desc_rptr_q <= '0;
        end else begin
            if (desc_push) desc_wptr_q <= desc_wptr_q + DescPtrOne;
            if (desc_pop)  desc_rptr_q <= desc_rptr_q + DescPtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (desc_push) begin
            desc_addr_mem[desc_wptr_q[DescAw-1:0]] <= desc_addr;
            desc_size_mem[desc_wptr_q[DescAw-1:0]] <= desc_size;
        end
    end

    // ---------------------------------------------------------------- completion FIFO
    logic [16:0]     cpl_mem [DONE_DEPTH];
    logic [DoneAw:0] cpl_wptr_q, cpl_rptr_q;
    logic            cpl_empty, cpl_full, cpl_pop, cpl_push, cpl_ovf;
    logic            cpl_req, cpl_last;
    logic [15:0]     cpl_seq;

    assign cpl_empty = (cpl_wptr_q == cpl_rptr_q);
    assign cpl_full  = (cpl_wptr_q[DoneAw] != cpl_rptr_q[DoneAw]) &&
                       (cpl_wptr_q[DoneAw-1:0] == cpl_rptr_q[DoneAw-1:0]);
    assign cpl_pop   = !cpl_empty && done_ready;
    // A pop in the same cycle frees a slot, so a full FIFO only overflows without one.
    assign cpl_push  = cpl_req && (!cpl_full || cpl_pop);
    assign cpl_ovf   = cpl_req && cpl_full && !cpl_pop;
    // buf_cnt already counts the active buffer, so the active buffer's seq is buf_cnt - 1.
    assign cpl_seq   = buf_cnt - 16'd1;

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            cpl_wptr_q <= '0;
            cpl_rptr_q <= '0;
        end else begin
            if (cpl_push) cpl_wptr_q <= cpl_wptr_q + DonePtrOne;
            if (cpl_pop)  cpl_rptr_q <= cpl_rptr_q + DonePtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (cpl_push) begin
            cpl_mem[cpl_wptr_q[DoneAw-1:0]] <= {cpl_seq, cpl_last};
        end
    end

    assign done_valid             = !cpl_empty;
    assign {done_seq, done_last}  = cpl_mem[cpl_rptr_q[DoneAw-1:0]];

    // ---------------------------------------------------------------- control FSM
    // prog_load marks every transition into StProgram. On that edge the FIFO head is loaded
    // into the writer registers, the head is popped and buf_cnt advances. StProgram then
    // lasts one cycle, and that cycle is the update pulse.
    logic prog_load;

    always_comb begin
        state_d   = state_q;
        prog_load = 1'b0;
        cpl_req   = 1'b0;
        cpl_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (record_finish) begin
                    state_d  = StDone;
                    cpl_req  = (buf_cnt != 16'd0);
                    cpl_last = 1'b1;
                end else if (!desc_empty) begin
                    state_d   = StProgram;
                    prog_load = 1'b1;
                end
            end
            // The writer is still latching here, so events in this cycle are not acted on.
            StProgram: state_d = StActive;
            StActive: begin
                if (write_interrupt) begin
                    cpl_req = 1'b1;
                    if (record_finish) begin
                        cpl_last = 1'b1;
                        state_d  = StDone;
                    end else if (!desc_empty) begin
                        state_d   = StProgram;
                        prog_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (record_finish) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (write_interrupt) begin
                    cpl_req  = 1'b1;
                    cpl_last = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    assign desc_pop = prog_load;

    logic [AXI_ADDR_WIDTH-1:0] wb_addr_q, wb_size_q;
    logic [15:0]               buf_cnt_q;
    logic                      err_bad_q, err_ovf_q;

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q   <= StIdle;
            wb_addr_q <= '0;
            wb_size_q <= '0;
            buf_cnt_q <= '0;
            err_bad_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (prog_load) begin
                wb_addr_q <= desc_addr_mem[desc_rptr_q[DescAw-1:0]];
                wb_size_q <= desc_size_mem[desc_rptr_q[DescAw-1:0]];
                buf_cnt_q <= buf_cnt_q + 16'd1;
            end
            if (desc_fire && desc_bad) err_bad_q <= 1'b1;
            if (cpl_ovf)               err_ovf_q <= 1'b1;
        end
    end

    assign write_buf_addr   = wb_addr_q;
    assign write_buf_size   = wb_size_q;
    assign write_buf_update = (state_q == StProgram);
    assign buf_cnt          = buf_cnt_q;
    assign err_bad_desc     = err_bad_q;
    assign err_done_ovf     = err_ovf_q;
    assign starved          = (state_q == StIdle) && desc_empty && (buf_cnt_q != 16'd0);

endmodule

// File: tb/tb_rr_trace_buf_ctrl.sv
// Bench for rr_trace_buf_ctrl. Descriptors and completions that the bench expects are
// queued as stimulus is driven, and a monitor pops and compares them whenever the DUT
// pulses write_buf_update or transfers a completion.
module tb_rr_trace_buf_ctrl;

    logic        clk = 1'b0;
    logic        sync_rst_n = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [63:0] desc_addr = '0;
    logic [63:0] desc_size = '0;
    logic [63:0] write_buf_addr, write_buf_size;
    logic        write_buf_update;
    logic        write_interrupt = 1'b0;
    logic        record_finish = 1'b0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [15:0] done_seq;
    logic        done_last;
    logic        starved, err_bad_desc, err_done_ovf;
    logic [15:0] buf_cnt;

    rr_trace_buf_ctrl #(
        .AXI_ADDR_WIDTH (64),
        .DESC_DEPTH     (4),
        .DONE_DEPTH     (4)
    ) dut (
        .clk              (clk),
        .sync_rst_n       (sync_rst_n),
        .desc_valid       (desc_valid),
        .desc_ready       (desc_ready),
        .desc_addr        (desc_addr),
        .desc_size        (desc_size),
        .write_buf_addr   (write_buf_addr),
        .write_buf_size   (write_buf_size),
        .write_buf_update (write_buf_update),
        .write_interrupt  (write_interrupt),
        .record_finish    (record_finish),
        .done_valid       (done_valid),
        .done_ready       (done_ready),
        .done_seq         (done_seq),
        .done_last        (done_last),
        .starved          (starved),
        .err_bad_desc     (err_bad_desc),
        .err_done_ovf     (err_done_ovf),
        .buf_cnt          (buf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] addr; logic [63:0] size; } desc_t;
    typedef struct packed { logic [15:0] seq; logic last; } cpl_t;

    desc_t exp_upd_q[$];
    cpl_t  exp_cpl_q[$];
    desc_t mon_d;
    cpl_t  mon_c;
    int    checks = 0;
    int    errors = 0;
    int    upd_count = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (write_buf_update) begin
            upd_count++;
            check_eq("upd_expected", (exp_upd_q.size() != 0) ? 64'd1 : 64'd0, 64'd1);
            if (exp_upd_q.size() != 0) begin
                mon_d = exp_upd_q.pop_front();
                check_eq("upd_addr", write_buf_addr, mon_d.addr);
                check_eq("upd_size", write_buf_size, mon_d.size);
            end
        end
        if (done_valid && done_ready) begin
            check_eq("cpl_expected", (exp_cpl_q.size() != 0) ? 64'd1 : 64'd0, 64'd1);
            if (exp_cpl_q.size() != 0) begin
                mon_c = exp_cpl_q.pop_front();
                check_eq("done_seq", 64'(done_seq), 64'(mon_c.seq));
                check_eq("done_last", 64'(done_last), 64'(mon_c.last));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_rst_n      = 1'b0;
        desc_valid      = 1'b0;
        write_interrupt = 1'b0;
        record_finish   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_desc_ready", 64'(desc_ready), 64'd0);
        check_eq("rst_update", 64'(write_buf_update), 64'd0);
        check_eq("rst_done_valid", 64'(done_valid), 64'd0);
        check_eq("rst_buf_cnt", 64'(buf_cnt), 64'd0);
        check_eq("rst_starved", 64'(starved), 64'd0);
        check_eq("rst_errs", 64'({err_bad_desc, err_done_ovf}), 64'd0);
        check_eq("rst_wb_addr", write_buf_addr, 64'd0);
        check_eq("rst_wb_size", write_buf_size, 64'd0);
        exp_upd_q.delete();
        exp_cpl_q.delete();
        @(posedge clk);
        #1;
        sync_rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_rst", 64'(desc_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Offers a descriptor for up to 'bound' cycles; called and returns at posedge + 1.
    task automatic push_desc(input logic [63:0] a, input logic [63:0] s, input bit good,
                             input int bound, output bit acc);
        int n = 0;
        acc        = 1'b0;
        desc_valid = 1'b1;
        desc_addr  = a;
        desc_size  = s;
        while (!acc && n < bound) begin
            @(negedge clk);
            if (desc_ready) acc = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        desc_valid = 1'b0;
        if (acc && good) exp_upd_q.push_back({a, s});
    endtask

    task automatic pulse(input bit irq, input bit fin);
        write_interrupt = irq;
        record_finish   = fin;
        @(posedge clk);
        #1;
        write_interrupt = 1'b0;
        record_finish   = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        bit saw;
        int base;

        // Single buffer, latency, then finish and interrupt together.
        do_reset();
        done_ready = 1'b1;
        base = upd_count;
        push_desc(64'h1000_0000, 64'd1024, 1'b1, 20, acc);
        check_eq("t1_accept", 64'(acc), 64'd1);
        saw = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (write_buf_update) saw = 1'b1;
        end
        check_eq("t1_latency", 64'(saw), 64'd1);
        @(posedge clk);
        #1;
        wait_cycles(2);
        check_eq("t1_buf_cnt", 64'(buf_cnt), 64'd1);
        check_eq("t1_one_pulse", 64'(upd_count - base), 64'd1);
        check_eq("t1_addr_held", write_buf_addr, 64'h1000_0000);
        check_eq("t1_size_held", write_buf_size, 64'd1024);
        check_eq("t1_not_starved", 64'(starved), 64'd0);
        exp_cpl_q.push_back({16'd0, 1'b1});
        pulse(1'b1, 1'b1);
        wait_cycles(3);
        check_eq("t1_done_ready_low", 64'(desc_ready), 64'd0);
        check_eq("t1_cpl_drained", 64'(exp_cpl_q.size()), 64'd0);

        // Two buffers, two interrupts, then finish from IDLE.
        do_reset();
        done_ready = 1'b1;
        base = upd_count;
        push_desc(64'h2000_0000, 64'd4096, 1'b1, 20, acc);
        check_eq("t2_accept_a", 64'(acc), 64'd1);
        push_desc(64'h3000_0000, 64'd8192, 1'b1, 20, acc);
        check_eq("t2_accept_b", 64'(acc), 64'd1);
        wait_cycles(3);
        exp_cpl_q.push_back({16'd0, 1'b0});
        pulse(1'b1, 1'b0);
        wait_cycles(3);
        check_eq("t2_two_updates", 64'(upd_count - base), 64'd2);
        check_eq("t2_addr_b", write_buf_addr, 64'h3000_0000);
        exp_cpl_q.push_back({16'd1, 1'b0});
        pulse(1'b1, 1'b0);
        wait_cycles(2);
        check_eq("t2_starved", 64'(starved), 64'd1);
        check_eq("t2_buf_cnt", 64'(buf_cnt), 64'd2);
        exp_cpl_q.push_back({16'd1, 1'b1});
        pulse(1'b0, 1'b1);
        wait_cycles(3);
        check_eq("t2_starved_clr", 64'(starved), 64'd0);
        check_eq("t2_done_ready_low", 64'(desc_ready), 64'd0);
        pulse(1'b1, 1'b0);
        wait_cycles(3);
        check_eq("t2_irq_in_done", 64'(done_valid), 64'd0);
        push_desc(64'h7000_0000, 64'd64, 1'b0, 4, acc);
        check_eq("t2_no_accept_done", 64'(acc), 64'd0);
        check_eq("t2_cpl_drained", 64'(exp_cpl_q.size()), 64'd0);

        // Five descriptors into a four-entry FIFO, then reset while active.
        do_reset();
        done_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_desc(64'h4000_0000 + 64'(i) * 64'h1000, 64'd64 * 64'(i + 1), 1'b1, 20, acc);
            check_eq("t3_accept", 64'(acc), 64'd1);
        end
        wait_cycles(1);
        check_eq("t3_full_ready", 64'(desc_ready), 64'd0);
        check_eq("t3_buf_cnt", 64'(buf_cnt), 64'd1);
        push_desc(64'h4800_0000, 64'd64, 1'b1, 4, acc);
        check_eq("t3_sixth_refused", 64'(acc), 64'd0);
        exp_cpl_q.push_back({16'd0, 1'b0});
        pulse(1'b1, 1'b0);
        @(negedge clk);
        check_eq("t3_ready_after_pop", 64'(desc_ready), 64'd1);
        @(posedge clk);
        #1;
        wait_cycles(2);
        check_eq("t3_buf_cnt2", 64'(buf_cnt), 64'd2);
        check_eq("t3_cpl_drained", 64'(exp_cpl_q.size()), 64'd0);
        do_reset();
        base = upd_count;
        wait_cycles(6);
        check_eq("t3_rst_no_update", 64'(upd_count - base), 64'd0);
        check_eq("t3_rst_no_cpl", 64'(done_valid), 64'd0);
        check_eq("t3_rst_buf_cnt", 64'(buf_cnt), 64'd0);

        // Malformed descriptors are accepted and dropped.
        done_ready = 1'b1;
        base = upd_count;
        push_desc(64'h1000_0000, 64'd100, 1'b0, 20, acc);
        check_eq("t4_accept_size", 64'(acc), 64'd1);
        push_desc(64'h0000_1004, 64'd1024, 1'b0, 20, acc);
        check_eq("t4_accept_addr", 64'(acc), 64'd1);
        push_desc(64'h5000_0000, 64'd0, 1'b0, 20, acc);
        check_eq("t4_accept_zero", 64'(acc), 64'd1);
        wait_cycles(5);
        check_eq("t4_err_bad", 64'(err_bad_desc), 64'd1);
        check_eq("t4_no_update", 64'(upd_count - base), 64'd0);
        check_eq("t4_buf_cnt", 64'(buf_cnt), 64'd0);
        check_eq("t4_not_starved", 64'(starved), 64'd0);
        check_eq("t4_no_ovf", 64'(err_done_ovf), 64'd0);
        push_desc(64'h6000_0000, 64'd2048, 1'b1, 20, acc);
        wait_cycles(4);
        check_eq("t4_good_after_bad", 64'(upd_count - base), 64'd1);
        check_eq("t4_err_sticky", 64'(err_bad_desc), 64'd1);

        // Completion FIFO overflow while the host is not draining.
        do_reset();
        done_ready = 1'b0;
        base = upd_count;
        for (int i = 0; i < 5; i++) begin
            push_desc(64'h8000_0000 + 64'(i) * 64'h40, 64'd128, 1'b1, 20, acc);
            check_eq("t5_accept", 64'(acc), 64'd1);
        end
        wait_cycles(2);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_cpl_q.push_back({16'(i), 1'b0});
            pulse(1'b1, 1'b0);
            wait_cycles(2);
        end
        check_eq("t5_err_ovf", 64'(err_done_ovf), 64'd1);
        check_eq("t5_buf_cnt", 64'(buf_cnt), 64'd5);
        check_eq("t5_updates", 64'(upd_count - base), 64'd5);
        check_eq("t5_held", 64'(done_valid), 64'd1);
        check_eq("t5_starved", 64'(starved), 64'd1);
        done_ready = 1'b1;
        wait_cycles(8);
        check_eq("t5_drained_valid", 64'(done_valid), 64'd0);
        check_eq("t5_cpl_drained", 64'(exp_cpl_q.size()), 64'd0);
        check_eq("t5_upd_drained", 64'(exp_upd_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
